// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with true full/empty, programmable
//            almost-full/almost-empty, full-range occupancy count and sticky
//            overflow/underflow error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH     data word width in bits
//   DEPTH     address bits; capacity N = 2**DEPTH words
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//   Legal: 0 < AE_LEVEL < AF_LEVEL < N
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   data_in       in   write data
//   write_en      in   write request
//   read_en       in   read request (FWFT build: head-word acknowledge)
//   clr_err       in   clears overflow/underflow
//   data_out      out  read data
//   data_valid    out  data_out carries a valid word
//   full, empty   out  count == N / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..N
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
// Build option:
//   SYNC_FIFO_FWFT_EN  defined -> first-word-fall-through read port;
//                      undefined -> registered read with 1-cycle latency
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 6,
    parameter int AF_LEVEL = 48,
    parameter int AE_LEVEL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_en,
    input  logic             read_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             c_N        = 1 << DEPTH;
    localparam logic [DEPTH:0] c_CNT_FULL = (DEPTH+1)'(c_N);
    localparam logic [DEPTH:0] c_CNT_AF   = (DEPTH+1)'(AF_LEVEL);
    localparam logic [DEPTH:0] c_CNT_AE   = (DEPTH+1)'(AE_LEVEL);
    localparam logic [DEPTH:0] c_CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] c_PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] r_mem [c_N];
    logic [DEPTH-1:0] r_wptr;
    logic [DEPTH-1:0] r_rptr;
    logic [DEPTH:0]   r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [DEPTH:0]   w_count_nxt;

    // A read frees a slot in the same edge, so a full FIFO can still accept
    // a write when a read is accepted alongside it.
    always_comb begin
        w_rd_ok     = read_en & ~r_empty;
        w_wr_ok     = write_en & (~r_full | w_rd_ok);
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // Pointers, occupancy and flags. Status flags are computed from the
    // next-state count so they are exact right after the updating edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_CNT_FULL);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_CNT_AF);
            r_almost_empty <= (w_count_nxt <= c_CNT_AE);
            // New error takes precedence over a coincident clear.
            r_overflow     <= (write_en & ~w_wr_ok) | (r_overflow  & ~clr_err);
            r_underflow    <= (read_en  & ~w_rd_ok) | (r_underflow & ~clr_err);
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wptr] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly from storage; all terms are registered.
    assign data_out   = r_empty ? '0 : r_mem[r_rptr];
    assign data_valid = ~r_empty;
`else
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rptr];
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
`endif

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param against a queue-based
//            reference model (directed scenarios plus randomized traffic).
//            Honours SYNC_FIFO_FWFT_EN to select the expected read behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 48;
    localparam int AE    = 16;
    localparam int N     = 1 << DEPTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             write_en = 1'b0;
    logic             read_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [DEPTH:0]   count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_dv = 1'b0;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
        .read_en(read_en), .clr_err(clr_err), .data_out(data_out),
        .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Expected {full, empty, almost_full, almost_empty, count, ovf, udf, valid}
    function automatic logic [13:0] exp_status();
        int n = m_q.size();
        logic dv;
`ifdef SYNC_FIFO_FWFT_EN
        dv = (n > 0);
`else
        dv = m_dv;
`endif
        return {n == N, n == 0, n >= AF, n <= AE, 7'(n), m_ovf, m_udf, dv};
    endfunction

    function automatic logic [WIDTH-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
        return (m_q.size() > 0) ? m_q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    // Drive one clock of stimulus and advance the model by the FIFO rules.
    task automatic cycle(input logic we, input logic re, input logic [WIDTH-1:0] din,
                         input logic clr, input logic rs);
        bit rd, wr;
        write_en = we; read_en = re; data_in = din; clr_err = clr; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_dv = 1'b0;
        end else begin
            rd = re && (m_q.size() > 0);
            wr = we && ((m_q.size() < N) || rd);
            m_dv = rd;
            if (rd) m_dout = m_q.pop_front();
            if (wr) m_q.push_back(din);
            m_ovf = (we && !wr) || (m_ovf && !clr);
            m_udf = (re && !rd) || (m_udf && !clr);
        end
        #1;
        write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid}
            !== 14'b0101_0000000_000) begin
            n_fail++;
            $display("FAIL reset_status: got %b want %b",
                     {full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid},
                     14'b0101_0000000_000);
        end
        n_checks++;
        if (data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h want 00", data_out);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
            n_checks++;
            if ({full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid}
                !== exp_status()) begin
                n_fail++;
                $display("FAIL fill_status[%0d]: got %b want %b", i,
                         {full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid},
                         exp_status());
            end
        end
        cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        n_checks++;
        if ({full, count, overflow} !== {1'b1, 7'd64, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_write: got full=%b count=%0d ovf=%b want 1 64 1",
                     full, count, overflow);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
            n_checks++;
            if ({data_out, full, empty, almost_full, almost_empty, count, underflow, data_valid}
                !== {exp_dout(), exp_status()[13:3], exp_status()[1:0]}) begin
                n_fail++;
                $display("FAIL drain[%0d]: got dout=%h valid=%b count=%0d want dout=%h status=%b",
                         i, data_out, data_valid, count, exp_dout(), exp_status());
            end
        end
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        n_checks++;
        if ({underflow, empty, count} !== {1'b1, 1'b1, 7'd0}) begin
            n_fail++;
            $display("FAIL underflow_read: got udf=%b empty=%b count=%0d want 1 1 0",
                     underflow, empty, count);
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if ({data_out, data_valid} !== {8'h3F, 1'b0}) begin
            n_fail++;
            $display("FAIL underflow_hold: got dout=%h valid=%b want 3f 0", data_out, data_valid);
        end
`endif
    endtask

    task automatic test_clr_err();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_err: got ovf=%b udf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, WIDTH'(8'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
            n_checks++;
            if ({data_out, data_valid, count} !== {exp_dout(), exp_status()[0], exp_status()[9:3]}) begin
                n_fail++;
                $display("FAIL wrap_read[%0d]: got dout=%h valid=%b count=%0d want %h %b %0d",
                         i, data_out, data_valid, count, exp_dout(), exp_status()[0], m_q.size());
            end
        end
        n_checks++;
        if ({count, empty} !== {7'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_end: got count=%0d empty=%b want 0 1", count, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        n_checks++;
        if ({count, full, overflow} !== {7'd64, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_rw: got count=%0d full=%b ovf=%b want 64 1 0", count, full, overflow);
        end
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
            n_checks++;
            if (data_out !== exp_dout()) begin
                n_fail++;
                $display("FAIL full_rw_drain[%0d]: got %h want %h", i, data_out, exp_dout());
            end
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (data_out !== 8'hC3) begin
            n_fail++;
            $display("FAIL full_rw_last: got %h want c3", data_out);
        end
`endif
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        n_checks++;
        if ({count, underflow, empty} !== {7'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_rw: got count=%0d udf=%b empty=%b want 1 1 0", count, underflow, empty);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        n_checks++;
        if ({full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid, data_out}
            !== {14'b0101_0000000_000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid: got status=%b dout=%h want 01010000000000 00",
                     {full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid},
                     data_out);
        end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        n_checks++;
        if ({data_out, data_valid} !== {8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL fwft_head: got dout=%h valid=%b want 5a 1", data_out, data_valid);
        end
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        n_checks++;
        if ({data_valid, empty} !== 2'b01) begin
            n_fail++;
            $display("FAIL fwft_pop: got valid=%b empty=%b want 0 1", data_valid, empty);
        end
    endtask
`endif

    task automatic test_random();
        int wbias, rbias;
        for (int p = 0; p < 6; p++) begin
            wbias = (p % 2 == 0) ? 80 : 25;
            rbias = (p % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < rbias,
                      WIDTH'($urandom), $urandom_range(0, 99) < 4, $urandom_range(0, 499) == 0);
                n_checks++;
                if ({data_out, full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid}
                    !== {exp_dout(), exp_status()}) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d]: got dout=%h status=%b want dout=%h status=%b",
                             p, i, data_out,
                             {full, empty, almost_full, almost_empty, count, overflow, underflow, data_valid},
                             exp_dout(), exp_status());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_clr_err();
        test_wrap();
        test_simultaneous();
        test_clr_err();
        test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the 64x8 homework FIFO.
- Width and depth are generic.
- Flag set: true full/empty, programmable almost-full/almost-empty, full-range occupancy count, sticky overflow/underflow error flags.
- Sits between a producer and consumer in the same clock domain; a protected buffer for RAM-homework datapaths.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 6, address bits; capacity N = 2^DEPTH words.
- AF_LEVEL, 48, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 16, almost_empty asserts when count <= AE_LEVEL.
- Legal settings: 0 < AE_LEVEL < AF_LEVEL < N.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  write data.
- write_en  in  1  write request.
- read_en  in  1  read request.
- clr_err  in  1  clears overflow/underflow (sync, 1-cycle pulse).
- data_out  out  WIDTH  read data.
- data_valid  out  1  data_out carries a newly read word.
- full  out  1  count == N.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  DEPTH+1  occupancy, 0..N.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=1 at edge) has priority over all other activity, including mid-transfer.
  - Outputs after reset: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_valid=0, data_out=0, overflow=0, underflow=0.
  - Read/write pointers cleared. Memory contents are not reset.
- Storage and pointers:
  - Dual-port array of N x WIDTH words.
  - Write pointer and read pointer are DEPTH bits wide and wrap N-1 -> 0 naturally.
  - count is a separate DEPTH+1-bit register and never wraps.
- Write acceptance: wr_ok = write_en & (!full | rd_ok). On wr_ok, mem[wptr] <= data_in and wptr++.
- Read acceptance: rd_ok = read_en & !empty. On rd_ok, data_out <= mem[rptr], rptr++, and data_valid=1 for exactly the following cycle.
- Read latency: 1 clock. data_out holds its last value when no read is accepted; data_valid=0 otherwise.
- count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Simultaneous operations:
  - Full with read+write: both accepted, count stays N, full stays 1.
  - Empty with read+write: write accepted, read rejected (underflow set), count becomes 1.
- Rejected operations:
  - write_en & !wr_ok sets overflow; memory and pointers unchanged.
  - read_en & !rd_ok sets underflow.
- Error flags:
  - Sticky until clr_err or rst.
  - If clr_err coincides with a new error, the flag is set (set wins).
- Status flags (full, empty, almost_full, almost_empty) are registered and derived from the next-state count, so they are exact in the cycle after the edge that changed count. No combinational path from inputs to any output.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out = mem[rptr] whenever !empty; data_valid = !empty.
  - read_en acts as an acknowledge that pops the head word.
  - A word written to an empty FIFO at edge k is visible on data_out, with data_valid=1, after edge k.
  - count includes the presented head word.
  - All acceptance, flag and error rules are unchanged.
- Undefined: standard mode as described in Behaviour (1-cycle registered read).

Test Plan (defaults: WIDTH=8, DEPTH=6, AF=48, AE=16):
- Reset, then idle -> empty=1, almost_empty=1, count=0, full=0, data_valid=0, overflow=0, underflow=0.
- Write 0x00..0x3F (64 writes), then one extra write of 0xAA -> almost_full at count=48; full=1 at count=64; overflow=1; count stays 64; 0xAA not stored.
- Read 64 words -> data_out = 0x00..0x3F in order, each 1 cycle after its read_en, data_valid high each time; empty=1 at end; a 65th read sets underflow and leaves data_out=0x3F.
- Pointer wrap:
  - Fill 40, read 40, then write 0x50..0x77 (40 words) so pointers cross 63->0.
  - Read back -> 0x50..0x77 in order; count returns to 0.
- Simultaneous operations:
  - Full plus read_en & write_en of 0xC3 -> count=64, full held; 0xC3 read out last after draining.
  - Empty plus both -> count=1, underflow=1.
- clr_err pulse -> overflow and underflow return to 0. rst asserted at count=30 mid-burst -> all outputs at reset values in the next cycle. FWFT build: single write 0x5A into empty -> data_out=0x5A, data_valid=1 the next cycle, no read_en needed.
